// File: rtl/seq_nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package seq_nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_slice_4b.sv
// Purely combinational 4-bit ripple-carry slice; c_msb is the carry into bit 3,
// exposed so the caller can form signed overflow on the top nibble.
module add_slice_4b
    import seq_nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out,
    output logic                c_msb
);

    logic [NIBBLE_W:0] w_carry;

    assign w_carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_msb = w_carry[NIBBLE_W-1];
    assign c_out = w_carry[NIBBLE_W];

endmodule

// File: rtl/seq_nibble_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, one nibble per clock, LSB nibble first.
// Define SEQ_NIBBLE_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_nibble_adder
    import seq_nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SEQ_NIBBLE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic [NIBBLE_W-1:0] w_a_nib [NIB];
    logic [NIBBLE_W-1:0] w_b_nib [NIB];
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic [WIDTH-1:0]   w_sum_next;

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
            assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign w_last   = (r_idx == IDX_W'(NIB - 1));
    assign w_accept = in_valid && w_in_ready;

`ifdef SEQ_NIBBLE_ADDER_OVF_EN
    logic w_c_msb;
    logic r_ovf;
`else
    logic w_c_msb_unused;
`endif

    add_slice_4b u_slice (
        .a     (w_a_nib[r_idx]),
        .b     (w_b_nib[r_idx]),
        .c_in  (r_carry),
        .sum   (w_slice_sum),
        .c_out (w_slice_cout),
`ifdef SEQ_NIBBLE_ADDER_OVF_EN
        .c_msb (w_c_msb)
`else
        .c_msb (w_c_msb_unused)
`endif
    );

    // Only the nibble selected by r_idx changes; the rest of the result holds.
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < NIB; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sum_next[i*NIBBLE_W +: NIBBLE_W] = w_slice_sum;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Subtraction is A + ~B + 1, so the +1 rides in on the carry.
                r_a     <= a;
                r_b     <= op_sub ? ~b : b;
                r_carry <= op_sub ? 1'b1 : c_in;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_sum   <= w_sum_next;
                r_carry <= w_slice_cout;
                r_idx   <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef SEQ_NIBBLE_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= w_c_msb ^ w_slice_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_carry;

endmodule

// File: tb/tb_seq_nibble_adder.sv
// Self-checking bench for seq_nibble_adder: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_seq_nibble_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SEQ_NIBBLE_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_nibble_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SEQ_NIBBLE_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .c_out     (c_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        longint ua, ub, sa, sb, r, sr, smax, smin;
        ua   = longint'(ma);
        ub   = longint'(mb);
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (msub) begin
            r  = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + longint'(mcin);
            co = r[W];
            sr = sa + sb + longint'(mcin);
        end
        s  = r[W-1:0];
        ov = (sr > smax) || (sr < smin);
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic tcin, input logic tsub, input int hold);
        logic [W-1:0] es;
        logic         eco, eov;
        int           lat;
        int           guard;
        model(ta, tb2, tcin, tsub, es, eco, eov);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready_before_accept"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb2;
        c_in     = tcin;
        op_sub   = tsub;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        // Scramble inputs after the accept edge; the result must not depend on them.
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        c_in     = 1'($urandom);
        op_sub   = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(NIB + 1));
        check({tag, " sum"}, 64'(sum), 64'(es));
        check({tag, " c_out"}, 64'(c_out), 64'(eco));
`ifdef SEQ_NIBBLE_ADDER_OVF_EN
        check({tag, " ovf"}, 64'(ovf), 64'(eov));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            @(negedge clk);
            check({tag, " hold_state"}, {60'd0, out_valid, in_ready, c_out, 1'b0},
                  {60'd0, 1'b1, 1'b0, eco, 1'b0});
            check({tag, " hold_sum"}, 64'(sum), 64'(es));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " after_handshake"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        $display("[TB] %s a=%h b=%h cin=%0d sub=%0d -> sum=%h c_out=%0d lat=%0d",
                 tag, ta, tb2, tcin, tsub, es, eco, lat);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           seen;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_c_out", 64'(c_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add",        16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op("ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op("sub_ok",     16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        run_op("sub_equal",  16'h8000, 16'h8000, 1'b0, 1'b1, 0);
        run_op("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op("backpress",  16'hA5C3, 16'h5A3C, 1'b1, 1'b0, 10);

        // Reset two cycles after accept: the operation must vanish.
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; op_sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_state", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        check("midrun_rst_sum", 64'(sum), 64'd0);
        check("midrun_rst_c_out", 64'(c_out), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrun_rst_no_out_valid", 64'(seen), 64'd0);
        $display("[TB] midrun_rst discarded in-flight op, out_valid pulses=%0d", seen);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
